// File: rtl/m_muldiv.sv
// Iterative radix-2 RISC-V M-extension multiply/divide unit: one shift-add or shift-subtract step per clock.
// Define MULDIV_SPECIAL_FAST_EN to let divide-by-zero, signed overflow and zero-operand multiplies skip RUN.
module m_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic             i_clk,
    input  logic             i_reset_n,
    input  logic             i_start,
    input  logic [2:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_busy,
    output logic             o_done,
    output logic [WIDTH-1:0] o_result
);

    localparam int CW = $clog2(WIDTH);

    // funct3 encodings that need individual decoding; the rest fall out of i_op[2] / i_op[0].
    localparam logic [2:0] OP_MUL    = 3'b000;
    localparam logic [2:0] OP_MULH   = 3'b001;
    localparam logic [2:0] OP_MULHSU = 3'b010;
    localparam logic [2:0] OP_DIV    = 3'b100;
    localparam logic [2:0] OP_REM    = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_FIX
    } state_e;

    state_e             state_q, state_d;
    logic [2:0]         op_q, op_d;
    logic               neg_q, neg_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opnd_q, opnd_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic               done_q, done_d;

    // Operand decode at the start edge.
    logic             in_div;
    logic             a_signed, b_signed;
    logic             a_neg, b_neg;
    logic             div_by_zero;
    logic             start_neg;
    logic [WIDTH-1:0] abs_a, abs_b;

    assign in_div      = i_op[2];
    assign a_signed    = (i_op == OP_MULH) || (i_op == OP_MULHSU) || (i_op == OP_DIV) || (i_op == OP_REM);
    assign b_signed    = (i_op == OP_MULH) || (i_op == OP_DIV) || (i_op == OP_REM);
    assign a_neg       = a_signed && i_a[WIDTH-1];
    assign b_neg       = b_signed && i_b[WIDTH-1];
    assign abs_a       = a_neg ? -i_a : i_a;
    assign abs_b       = b_neg ? -i_b : i_b;
    assign div_by_zero = (i_b == '0);

    // Remainder follows the dividend; a divide-by-zero quotient stays all ones regardless of signs.
    always_comb begin
        if (!in_div) begin
            start_neg = a_neg ^ b_neg;
        end else if (i_op[1]) begin
            start_neg = a_neg;
        end else begin
            start_neg = (a_neg ^ b_neg) && !div_by_zero;
        end
    end

`ifdef MULDIV_SPECIAL_FAST_EN
    logic               signed_ovf;
    logic               mul_zero;
    logic               fast_hit;
    logic [2*WIDTH-1:0] fast_acc;

    assign signed_ovf = in_div && !i_op[0] && (i_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&i_b);
    assign mul_zero   = !in_div && ((i_a == '0) || (i_b == '0));
    assign fast_hit   = (in_div && div_by_zero) || signed_ovf || mul_zero;

    // Preload the accumulator with what RUN would have left behind, so FIX is shared.
    always_comb begin
        if (in_div && div_by_zero) begin
            fast_acc = {abs_a, {WIDTH{1'b1}}};
        end else if (signed_ovf) begin
            fast_acc = {{WIDTH{1'b0}}, abs_a};
        end else begin
            fast_acc = '0;
        end
    end
`endif

    // One iteration step. acc holds {hi, lo}: product/multiplier for mul, remainder/quotient for div.
    logic [WIDTH-1:0]   acc_hi, acc_lo;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     rem_shift;
    logic               rem_fits;
    logic [WIDTH-1:0]   rem_sub;
    logic [2*WIDTH-1:0] div_next;

    assign acc_hi    = acc_q[2*WIDTH-1:WIDTH];
    assign acc_lo    = acc_q[WIDTH-1:0];
    assign mul_sum   = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd_q} : {(WIDTH+1){1'b0}});
    assign mul_next  = {mul_sum, acc_lo[WIDTH-1:1]};
    assign rem_shift = {acc_hi, acc_lo[WIDTH-1]};
    assign rem_fits  = (rem_shift >= {1'b0, opnd_q});
    assign rem_sub   = rem_shift[WIDTH-1:0] - opnd_q;
    assign div_next  = rem_fits ? {rem_sub, acc_lo[WIDTH-2:0], 1'b1}
                                : {rem_shift[WIDTH-1:0], acc_lo[WIDTH-2:0], 1'b0};

    // Sign correction and half selection for FIX.
    logic [2*WIDTH-1:0] mul_prod;
    logic [WIDTH-1:0]   div_pick, div_fixed;

    assign mul_prod  = neg_q ? -acc_q : acc_q;
    assign div_pick  = op_q[1] ? acc_hi : acc_lo;
    assign div_fixed = neg_q ? -div_pick : div_pick;

    // NOTE: every _d gets its hold value first so no path through this block can infer a latch.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        acc_d    = acc_q;
        opnd_d   = opnd_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    op_d    = i_op;
                    neg_d   = start_neg;
                    cnt_d   = '0;
                    acc_d   = {{WIDTH{1'b0}}, (in_div ? abs_a : abs_b)};
                    opnd_d  = in_div ? abs_b : abs_a;
                    state_d = S_RUN;
`ifdef MULDIV_SPECIAL_FAST_EN
                    if (fast_hit) begin
                        acc_d   = fast_acc;
                        state_d = S_FIX;
                    end
`endif
                end
            end
            S_RUN: begin
                acc_d = op_q[2] ? div_next : mul_next;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH-1)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                if (op_q[2]) begin
                    result_d = div_fixed;
                end else if (op_q == OP_MUL) begin
                    result_d = mul_prod[WIDTH-1:0];
                end else begin
                    result_d = mul_prod[2*WIDTH-1:WIDTH];
                end
                done_d  = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q  <= S_IDLE;
            op_q     <= '0;
            neg_q    <= 1'b0;
            acc_q    <= '0;
            opnd_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            acc_q    <= acc_d;
            opnd_q   <= opnd_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    assign o_busy   = (state_q != S_IDLE);
    assign o_done   = done_q;
    assign o_result = result_q;

endmodule

// File: doc/m_muldiv.md
# m_muldiv

Iterative multiply/divide unit that extends the processor's single-cycle ALU with the RISC-V M-extension operations. It is parametrised in operand width and accepts a single operation through a start/busy/done handshake. It computes one radix-2 step per clock and returns a registered result with constant latency. It sits beside the ALU in the execute stage; the core stalls on `o_busy`.

## Interface
- `WIDTH`, 32, operand and result width in bits (≥ 4, even).

- `i_clk` input 1: clock; all state changes on the rising edge.
- `i_reset_n` input 1: asynchronous, active-low reset.
- `i_start` input 1: request; sampled only when `o_busy`=0.
- `i_op` input 3: operation, RISC-V funct3 encoding. 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `i_a` input WIDTH: rs1 operand (dividend / multiplicand).
- `i_b` input WIDTH: rs2 operand (divisor / multiplier).
- `o_busy` output 1: operation in flight; new starts ignored.
- `o_done` output 1: one-cycle pulse; `o_result` valid.
- `o_result` output WIDTH: result; holds until the next completion.

## Operation
- Reset values: `o_busy`=0, `o_done`=0, `o_result`=0, state IDLE, and all internal registers 0.
- States and transitions:
  - **IDLE**: on `i_start`=1, latch the op, take absolute values of the signed operands, record result-sign flags, clear the counter, go to RUN.
  - **RUN**: exactly WIDTH cycles.
    - Multiply: shift-add into a 2·WIDTH accumulator.
    - Divide: restoring shift-subtract; quotient and remainder are WIDTH wide each.
    - Counter reaches WIDTH−1 → FIX.
  - **FIX**: apply two's-complement sign correction, select the low or high half (mul) or the quotient or remainder (div), register `o_result`, pulse `o_done`, go to IDLE.
- Signedness:
  - MULH and DIV/REM treat both operands as signed.
  - MULHSU treats `i_a` as signed and `i_b` as unsigned.
  - MUL low half is sign-agnostic.
  - A remainder takes the sign of the dividend.
- Division by zero:
  - quotient = all ones (DIV and DIVU);
  - remainder = `i_a` unchanged.
- Signed overflow (`i_a` = −2^(WIDTH−1), `i_b` = −1):
  - quotient = `i_a`;
  - remainder = 0.
- Special cases keep the normal latency unless the configuration macro below is defined.
- `i_start` while `o_busy`=1 is ignored; operands are not re-sampled.
- Operands are latched at the start edge. Later changes to `i_a`, `i_b`, or `i_op` do not affect the operation in flight.

## Timing
- Start accepted at edge E0 (`i_start`=1, `o_busy`=0).
- `o_busy`=1 from just after E0 until the edge that raises `o_done`. It is 0 in the `o_done` cycle.
- `o_done`=1 for exactly the one cycle after edge E0+WIDTH+1 (WIDTH+1 busy cycles). `o_result` updates at that same edge.
- Back-to-back operation:
  - `i_start`=1 during the `o_done` cycle is accepted, since the unit is in IDLE.
  - `o_done` for that second operation occurs WIDTH+2 cycles later.
- Reset asserted mid-operation:
  - all outputs and state clear immediately and asynchronously;
  - no `o_done` is produced for the aborted operation;
  - after release, the unit is in IDLE.
- No combinational path from inputs to outputs.

## Configuration
- `MULDIV_SPECIAL_FAST_EN`:
  - Defined: the unit detects special cases in IDLE and skips RUN, going straight to FIX. `o_done` then pulses one cycle after E0+1, a latency of 2. Special cases are:
    - division by zero;
    - signed overflow;
    - any multiply with an operand equal to 0.
  - Undefined: every operation takes WIDTH+2 cycles. Results are identical in both builds.

## Test plan
- WIDTH=32, MUL a=7, b=−3 → `o_result`=0xFFFFFFEB, with `o_done` exactly 34 cycles after the start edge and `o_busy` high for 33 cycles.
- MULH a=0x80000000, b=0x80000000 → 0x40000000; MULHU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFE; MULHSU a=−1, b=0xFFFFFFFF → 0xFFFFFFFF.
- DIV a=−7, b=2 → −3 (0xFFFFFFFD); REM → −1; DIVU a=7, b=2 → 3; REMU → 1.
- DIVU a=5, b=0 → 0xFFFFFFFF and REMU → 5; DIV a=0x80000000, b=−1 → 0x80000000 and REM → 0. Latency is 34 without the macro and 2 with `MULDIV_SPECIAL_FAST_EN`.
- `i_start` pulsed at cycle 10 while busy → ignored: a single `o_done`, result unchanged. A start during the `o_done` cycle → accepted, with a second `o_done` 34 cycles later.
- `i_reset_n` low at cycle 15 of a DIV → `o_busy`, `o_done`, `o_result` go to 0 immediately; no `o_done` for the aborted operation; a new MUL 3×4 after release → 12.
